// File: rtl/lfsr_rng_if.sv
// lfsr_rng_if: request/valid word bus of the LFSR random-number generator.
//   master drives seed_load, seed_in, free_run and req.
//   slave drives busy, rnd_valid, rnd and lfsr_state.
interface lfsr_rng_if #(
    parameter int WIDTH    = 20,
    parameter int OUT_BITS = 8
);
    logic                seed_load;
    logic [WIDTH-1:0]    seed_in;
    logic                free_run;
    logic                req;
    logic                busy;
    logic                rnd_valid;
    logic [OUT_BITS-1:0] rnd;
    logic [WIDTH-1:0]    lfsr_state;
    modport master(output seed_load, seed_in, free_run, req,
                   input  busy, rnd_valid, rnd, lfsr_state);
    modport slave (input  seed_load, seed_in, free_run, req,
                   output busy, rnd_valid, rnd, lfsr_state);
endinterface

// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci LFSR producing OUT_BITS-wide random words on request.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : lfsr_rng_if.slave (seed_load/seed_in/free_run/req in;
//           busy/rnd_valid/rnd/lfsr_state out)
//   Optional feature: define LFSR_LOCKUP_RECOVER_EN to replace an all-zero
//   state (or a zero seed load) with SEED.
module lfsr_rng #(
    parameter int               WIDTH    = 20,
    parameter logic [WIDTH-1:0] TAPS     = 'h90000,
    parameter logic [WIDTH-1:0] SEED     = 'h1,
    parameter int               OUT_BITS = 8
) (
    input logic        clk,
    input logic        reset,
    lfsr_rng_if.slave  bus
);
    localparam int CW = $clog2(OUT_BITS + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} fsm_t;
    fsm_t                fsm_q, fsm_d;
    logic [WIDTH-1:0]    state_q, state_d;
    logic [OUT_BITS-1:0] col_q, col_d, rnd_q, rnd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                fb;
    logic [WIDTH-1:0]    shifted;
    logic [OUT_BITS-1:0] col_nx;
    assign fb      = ^(state_q & TAPS);
    assign shifted = {state_q[WIDTH-2:0], fb};
    // Truncating cast keeps this legal for OUT_BITS == 1 as well.
    assign col_nx  = OUT_BITS'({col_q, fb});
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        if (bus.seed_load) begin
            fsm_d = IDLE;
`ifdef LFSR_LOCKUP_RECOVER_EN
            state_d = (bus.seed_in == '0) ? SEED : bus.seed_in;
`else
            state_d = bus.seed_in;
`endif
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.req) begin
                        state_d = shifted;
                        col_d   = OUT_BITS'(fb);
                        cnt_d   = CW'(1);
                        fsm_d   = (OUT_BITS == 1) ? DONE : SHIFT;
                        rnd_d   = (OUT_BITS == 1) ? OUT_BITS'(fb) : rnd_q;
                    end else if (bus.free_run) begin
                        state_d = shifted;
                    end
                end
                SHIFT: begin
                    state_d = shifted;
                    col_d   = col_nx;
                    cnt_d   = cnt_q + CW'(1);
                    fsm_d   = (cnt_q == CW'(OUT_BITS - 1)) ? DONE : SHIFT;
                    rnd_d   = (cnt_q == CW'(OUT_BITS - 1)) ? col_nx : rnd_q;
                end
                default: fsm_d = IDLE;
            endcase
`ifdef LFSR_LOCKUP_RECOVER_EN
            // A stuck-at-zero register never leaves zero by shifting.
            state_d = (state_q == '0) ? SEED : state_d;
`endif
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= SEED;
            col_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
        end
    end
    assign bus.busy       = (fsm_q != IDLE);
    assign bus.rnd_valid  = (fsm_q == DONE);
    assign bus.rnd        = rnd_q;
    assign bus.lfsr_state = state_q;
endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: directed self-checking bench for lfsr_rng (default parameters).
module tb_lfsr_rng;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    lfsr_rng_if #(.WIDTH(20), .OUT_BITS(8)) bus();
    lfsr_rng dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        bus.seed_load = 1'b0;
        bus.seed_in   = '0;
        bus.free_run  = 1'b0;
        bus.req       = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_state", 32'(bus.lfsr_state), 32'h1);
        check("rst_busy",  32'(bus.busy), 32'h0);
        check("rst_valid", 32'(bus.rnd_valid), 32'h0);
        check("rst_rnd",   32'(bus.rnd), 32'h0);
        step();
        reset = 1'b0;
        // free-running walk: single one climbs until the tap at bit 16 fires
        bus.free_run = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            check($sformatf("free_state%0d", i), 32'(bus.lfsr_state),
                  (i == 17) ? 32'h20001 : (32'h1 << i));
            check($sformatf("free_busy%0d", i), 32'(bus.busy), 32'h0);
        end
        bus.free_run = 1'b0;
        // seed 0x80000 then one word: first fb=1, rest 0 -> rnd 0x80
        bus.seed_load = 1'b1;
        bus.seed_in   = 20'h80000;
        step();
        bus.seed_load = 1'b0;
        check("seed_state", 32'(bus.lfsr_state), 32'h80000);
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        check("w1_busy0", 32'(bus.busy), 32'h1);
        check("w1_state0", 32'(bus.lfsr_state), 32'h1);
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("w1_busy%0d", i), 32'(bus.busy), 32'h1);
            check($sformatf("w1_valid%0d", i), 32'(bus.rnd_valid), 32'h0);
        end
        step();
        check("w1_valid", 32'(bus.rnd_valid), 32'h1);
        check("w1_rnd",   32'(bus.rnd), 32'h80);
        check("w1_state", 32'(bus.lfsr_state), 32'h80);
        check("w1_busy7", 32'(bus.busy), 32'h1);
        step();
        check("w1_valid_end", 32'(bus.rnd_valid), 32'h0);
        check("w1_busy_end",  32'(bus.busy), 32'h0);
        check("w1_rnd_hold",  32'(bus.rnd), 32'h80);
        // asynchronous reset in the middle of a word
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        step(2);
        reset = 1'b1;
        #1;
        check("arst_state", 32'(bus.lfsr_state), 32'h1);
        check("arst_busy",  32'(bus.busy), 32'h0);
        check("arst_valid", 32'(bus.rnd_valid), 32'h0);
        check("arst_rnd",   32'(bus.rnd), 32'h0);
        step();
        reset = 1'b0;
        // req held high: words every 9 cycles, req in DONE ignored
        bus.req = 1'b1;
        step();
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("bk_valid%0d", i), 32'(bus.rnd_valid), 32'h0);
        end
        step();
        check("bk1_valid", 32'(bus.rnd_valid), 32'h1);
        check("bk1_rnd",   32'(bus.rnd), 32'h00);
        check("bk1_state", 32'(bus.lfsr_state), 32'h100);
        step();
        check("bk_done_busy",  32'(bus.busy), 32'h0);
        check("bk_done_state", 32'(bus.lfsr_state), 32'h100);
        step();
        check("bk2_busy0",  32'(bus.busy), 32'h1);
        check("bk2_state0", 32'(bus.lfsr_state), 32'h200);
        step(7);
        check("bk2_valid", 32'(bus.rnd_valid), 32'h1);
        check("bk2_rnd",   32'(bus.rnd), 32'h00);
        check("bk2_state", 32'(bus.lfsr_state), 32'h10000);
        step(2);
        step(7);
        check("bk3_valid", 32'(bus.rnd_valid), 32'h1);
        check("bk3_rnd",   32'(bus.rnd), 32'h90);
        check("bk3_state", 32'(bus.lfsr_state), 32'h90);
        bus.req = 1'b0;
        step();
        check("bk3_idle", 32'(bus.busy), 32'h0);
        // abort with seed_load on the 4th shift edge
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        step(2);
        bus.seed_load = 1'b1;
        bus.seed_in   = 20'h12345;
        step();
        bus.seed_load = 1'b0;
        check("ab_busy",  32'(bus.busy), 32'h0);
        check("ab_valid", 32'(bus.rnd_valid), 32'h0);
        check("ab_rnd",   32'(bus.rnd), 32'h90);
        check("ab_state", 32'(bus.lfsr_state), 32'h12345);
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("ab_novalid%0d", i), 32'(bus.rnd_valid), 32'h0);
        end
        // zero seed
        bus.seed_load = 1'b1;
        bus.seed_in   = '0;
        step();
        bus.seed_load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("z_state", 32'(bus.lfsr_state), 32'h1);
`else
        check("z_state", 32'(bus.lfsr_state), 32'h0);
`endif
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        step(7);
        check("z_valid", 32'(bus.rnd_valid), 32'h1);
        check("z_rnd",   32'(bus.rnd), 32'h00);
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("z_state_end", 32'(bus.lfsr_state), 32'h100);
`else
        check("z_state_end", 32'(bus.lfsr_state), 32'h0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
